// File: rtl/mv_avg_bcd.sv
`default_nettype none
// ============================================================================
// Module   : mv_avg_bcd
// Purpose  : Power-of-two moving average of ADC millivolt samples followed by
//            a sequential double-dabble conversion to four BCD digits.
// Revision : 1.0 - initial release
// ============================================================================
module mv_avg_bcd #(
    parameter int AVG_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample_mV,
    output logic [15:0] avg_mV,
    output logic [15:0] bcd_out,
    output logic        bcd_valid,
    output logic        busy
);

    localparam int          DEPTH     = 1 << AVG_LOG2;
    localparam int          SUM_W     = 16 + AVG_LOG2;
    localparam logic [15:0] c_MAX_DEC = 16'd9999;
    localparam logic [3:0]  c_LAST_IT = 4'd15;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_CONVERT = 1'b1
    } state_t;

    logic [15:0]      r_buf [DEPTH];
    logic [15:0]      w_old;
    logic [SUM_W-1:0] r_sum;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_load;
    logic        w_last;
    logic        r_pending;
    logic [3:0]  r_iter;
    logic [15:0] r_bin;
    logic [15:0] r_bcd;
    logic [15:0] w_adj;
    logic [31:0] w_pair;
    logic [15:0] w_clamped;

    // ------------------------------------------------------------------
    // Sample ring buffer; a single-entry window needs no pointer at all
    // ------------------------------------------------------------------
    generate
        if (AVG_LOG2 == 0) begin : g_single
            assign w_old = r_buf[0];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_buf[0] <= '0;
                end else if (sample_valid) begin
                    r_buf[0] <= sample_mV;
                end
            end
        end else begin : g_ring
            logic [AVG_LOG2-1:0] r_wr_ptr;

            assign w_old = r_buf[r_wr_ptr];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wr_ptr <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        r_buf[i] <= '0;
                    end
                end else if (sample_valid) begin
                    r_buf[r_wr_ptr] <= sample_mV;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                end
            end
        end
    endgenerate

    // The evicted sample is always part of the sum, so this cannot underflow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else if (sample_valid) begin
            r_sum <= r_sum + SUM_W'(sample_mV) - SUM_W'(w_old);
        end
    end

    assign avg_mV    = r_sum[SUM_W-1 -: 16];
    assign w_clamped = (avg_mV > c_MAX_DEC) ? c_MAX_DEC : avg_mV;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_state_next = S_CONVERT;
                    w_load       = 1'b1;
                end
            end
            S_CONVERT: begin
                if (r_iter == c_LAST_IT) begin
                    w_state_next = S_IDLE;
                    w_last       = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    generate
        for (genvar n = 0; n < 4; n++) begin : g_nib
            assign w_adj[4*n +: 4] = (r_bcd[4*n +: 4] >= 4'd5) ? (r_bcd[4*n +: 4] + 4'd3)
                                                               : r_bcd[4*n +: 4];
        end
    endgenerate

    assign w_pair = {w_adj, r_bin} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_iter    <= '0;
            r_bin     <= '0;
            r_bcd     <= '0;
            bcd_out   <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= w_last;
            if (w_load) begin
                r_bin  <= w_clamped;
                r_bcd  <= '0;
                r_iter <= '0;
            end else if (r_state == S_CONVERT) begin
                r_bin  <= w_pair[15:0];
                r_bcd  <= w_pair[31:16];
                r_iter <= r_iter + 1'b1;
            end
            if (w_last) begin
                bcd_out <= w_pair[31:16];
            end
            // A new sample wins over consumption so it is never lost
            if (sample_valid) begin
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign busy = (r_state == S_CONVERT);

endmodule
`default_nettype wire

// File: tb/tb_mv_avg_bcd.sv
`default_nettype none
// ============================================================================
// Module   : tb_mv_avg_bcd
// Purpose  : Self-checking bench for mv_avg_bcd with window 4 and window 1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mv_avg_bcd;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_sv = 1'b0, z_sv = 1'b0;
    logic [15:0] a_sm = '0, z_sm = '0;
    logic [15:0] a_avg, a_bcd, z_avg, z_bcd;
    logic        a_bv, a_busy, z_bv, z_busy;

    mv_avg_bcd #(.AVG_LOG2(2)) u_a (
        .clk(clk), .reset(reset), .sample_valid(a_sv), .sample_mV(a_sm),
        .avg_mV(a_avg), .bcd_out(a_bcd), .bcd_valid(a_bv), .busy(a_busy)
    );

    mv_avg_bcd #(.AVG_LOG2(0)) u_z (
        .clk(clk), .reset(reset), .sample_valid(z_sv), .sample_mV(z_sm),
        .avg_mV(z_avg), .bcd_out(z_bcd), .bcd_valid(z_bv), .busy(z_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int bcd_of(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return ((c / 1000) % 10) << 12 | ((c / 100) % 10) << 8 | ((c / 10) % 10) << 4 | (c % 10);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model: sample history, plain sums, conversion timeline
    // ------------------------------------------------------------------
    int hist [2][64];
    int wp [2], msum [2], pend [2], left [2], cval [2], ev [2], eb [2];
    int win [2] = '{4, 1};
    int cyc = 0;
    int a_scyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic sv;
            int   sm;
            sv = (k == 0) ? a_sv : z_sv;
            sm = (k == 0) ? int'(a_sm) : int'(z_sm);
            if (reset) begin
                for (int j = 0; j < 64; j++) hist[k][j] = 0;
                wp[k] = 0; msum[k] = 0; pend[k] = 0; left[k] = 0;
                cval[k] = 0; ev[k] = 0; eb[k] = 0;
            end else begin
                ev[k] = 0;
                if (left[k] > 0) begin
                    left[k]--;
                    if (left[k] == 0) begin
                        ev[k] = 1;
                        eb[k] = bcd_of(cval[k]);
                    end
                end else if (pend[k] != 0) begin
                    left[k] = 16;
                    cval[k] = msum[k] / win[k];
                    pend[k] = 0;
                end
                if (sv) begin
                    msum[k] = msum[k] + sm - hist[k][wp[k]];
                    hist[k][wp[k]] = sm;
                    wp[k] = (wp[k] + 1) % win[k];
                    pend[k] = 1;
                    if (k == 0) a_scyc = cyc;
                end
            end
        end
        if (reset) chk_en = 1'b1;
        cyc++;
    end

    // ------------------------------------------------------------------
    // Per-cycle compare plus pulse monitors
    // ------------------------------------------------------------------
    bit lat_en = 1'b0;
    int an = 0, zn = 0;
    int zcyc [4];
    int zval [4];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_avg",   int'(a_avg),  msum[0] / 4);
            chk("a_busy",  int'(a_busy), (left[0] > 0) ? 1 : 0);
            chk("a_valid", int'(a_bv),   ev[0]);
            chk("a_bcd",   int'(a_bcd),  eb[0]);
            chk("z_avg",   int'(z_avg),  msum[1]);
            chk("z_busy",  int'(z_busy), (left[1] > 0) ? 1 : 0);
            chk("z_valid", int'(z_bv),   ev[1]);
            chk("z_bcd",   int'(z_bcd),  eb[1]);
            if (a_bv) begin
                an++;
                if (lat_en) chk("latency", cyc - a_scyc, 18);
            end
            if (z_bv) begin
                if (zn < 4) begin
                    zcyc[zn] = cyc;
                    zval[zn] = int'(z_bcd);
                end
                zn++;
            end
        end
    end

    task automatic pulse_a(input int v);
        @(posedge clk); #1 a_sv = 1'b1; a_sm = 16'(v);
        @(posedge clk); #1 a_sv = 1'b0;
    endtask

    task automatic pulse_z(input int v);
        @(posedge clk); #1 z_sv = 1'b1; z_sm = 16'(v);
        @(posedge clk); #1 z_sv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int ramp [4] = '{825, 1650, 2475, 3300};
    int slide [5] = '{1250, 1500, 1750, 2000, 2000};
    int t0;

    initial begin
        // Reset and quiet period
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(100);
        chk("reset_no_valid_a", an, 0);
        chk("reset_no_valid_z", zn, 0);
        chk("reset_bcd", int'(a_bcd), 16'h0000);

        // Ramp-up with latency checks
        lat_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse_a(3300);
            chk("ramp_avg", int'(a_avg), ramp[i]);
            idle(38);
        end
        lat_en = 1'b0;
        chk("ramp_pulses", an, 4);
        chk("ramp_bcd", int'(a_bcd), 16'h3300);

        // Window slide and pointer wrap
        for (int i = 0; i < 4; i++) begin
            pulse_a(1000);
            idle(20);
        end
        for (int i = 0; i < 5; i++) begin
            pulse_a(2000);
            chk("slide_avg", int'(a_avg), slide[i]);
            idle(20);
            if (i == 0) chk("slide_bcd", int'(a_bcd), 16'h1250);
        end

        // Clamp and decimal extremes
        for (int i = 0; i < 4; i++) begin
            pulse_a(65535);
            idle(20);
        end
        chk("clamp_avg", int'(a_avg), 65535);
        chk("clamp_bcd", int'(a_bcd), 16'h9999);
        for (int i = 0; i < 4; i++) begin
            pulse_a(9999);
            idle(20);
        end
        chk("max_bcd", int'(a_bcd), 16'h9999);
        for (int i = 0; i < 4; i++) begin
            pulse_a(0);
            idle(20);
        end
        chk("zero_bcd", int'(a_bcd), 16'h0000);

        // Burst while busy on the single-entry window
        zn = 0;
        @(posedge clk); #1 z_sv = 1'b1; z_sm = 16'd100; t0 = cyc;
        @(posedge clk); #1 z_sm = 16'd200;
        @(posedge clk); #1 z_sm = 16'd300;
        @(posedge clk); #1 z_sv = 1'b0;
        idle(60);
        chk("burst_pulses", zn, 2);
        chk("burst_cyc0", zcyc[0] - t0, 18);
        chk("burst_val0", zval[0], 16'h0100);
        chk("burst_cyc1", zcyc[1] - t0, 35);
        chk("burst_val1", zval[1], 16'h0300);

        // Reset in the middle of a conversion
        pulse_z(500);
        idle(8);
        chk("midconv_busy", int'(z_busy), 1);
        zn = 0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("rst_busy", int'(z_busy), 0);
        chk("rst_bcd", int'(z_bcd), 16'h0000);
        idle(30);
        chk("rst_no_valid", zn, 0);
        pulse_z(42);
        idle(20);
        chk("after_rst_bcd", int'(z_bcd), 16'h0042);

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
